// File: rtl/stopwatch_clock.sv
// Four free-running 50 %-duty square-wave generators derived from CLK_REF.
// Each channel toggles its registered output every HALF_* reference cycles.
module stopwatch_clock #(
    parameter int unsigned HALF_FAST  = 100_000,
    parameter int unsigned HALF_2HZ   = 25_000_000,
    parameter int unsigned HALF_1HZ   = 50_000_000,
    parameter int unsigned HALF_BLINK = 12_500_000
) (
    input  logic CLK_REF,
    input  logic RST,
    output logic CLK_FAST,
    output logic CLK_2HZ,
    output logic CLK_1HZ,
    output logic CLK_BLINK
);

    localparam int NCH = 4;

    // Channel order: 0 fast, 1 2 Hz, 2 1 Hz, 3 blink.
    function automatic logic [31:0] terminal_count(input int ch);
        case (ch)
            0:       terminal_count = 32'(HALF_FAST - 1);
            1:       terminal_count = 32'(HALF_2HZ - 1);
            2:       terminal_count = 32'(HALF_1HZ - 1);
            default: terminal_count = 32'(HALF_BLINK - 1);
        endcase
    endfunction

    logic [31:0]    cnt_q [NCH];
    logic [31:0]    cnt_d [NCH];
    logic [NCH-1:0] wave_q;
    logic [NCH-1:0] wave_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wave_d = wave_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i] + 32'd1;
            if (cnt_q[i] == terminal_count(i)) begin
                cnt_d[i]  = '0;
                wave_d[i] = ~wave_q[i];
            end
        end
    end

    // Reset wins over a toggle due on the same edge, so outputs always restart low together.
    always_ff @(posedge CLK_REF) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (RST) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            wave_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
            wave_q <= wave_d;
        end
    end

    assign CLK_FAST  = wave_q[0];
    assign CLK_2HZ   = wave_q[1];
    assign CLK_1HZ   = wave_q[2];
    assign CLK_BLINK = wave_q[3];

endmodule

// File: tb/tb_stopwatch_clock.sv
// Self-checking bench for stopwatch_clock: vector table, period/alignment checks,
// mid-run reset sequence and random resets against an arithmetic reference model.
module tb_stopwatch_clock;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fast, hz2, hz1, blink;
    logic fast1, hz2_1, hz1_1, blink_1;

    always #5 clk = ~clk;

    stopwatch_clock #(
        .HALF_FAST(2), .HALF_2HZ(5), .HALF_1HZ(10), .HALF_BLINK(3)
    ) dut (
        .CLK_REF(clk), .RST(rst),
        .CLK_FAST(fast), .CLK_2HZ(hz2), .CLK_1HZ(hz1), .CLK_BLINK(blink)
    );

    stopwatch_clock #(
        .HALF_FAST(1), .HALF_2HZ(5), .HALF_1HZ(10), .HALF_BLINK(3)
    ) dut1 (
        .CLK_REF(clk), .RST(rst),
        .CLK_FAST(fast1), .CLK_2HZ(hz2_1), .CLK_1HZ(hz1_1), .CLK_BLINK(blink_1)
    );

    // Channel order for vectors: {fast, blink, 2hz, 1hz, fast(HALF=1)}, bit 4 down to 0.
    int unsigned half_of [5] = '{2, 3, 5, 10, 1};
    string       name_of [5] = '{"fast", "blink", "clk2hz", "clk1hz", "fast_div2"};

    typedef struct {
        logic       rst;
        logic [4:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference state: edges with RST=0 since the last reset edge.
    int unsigned k = 0;
    logic [4:0]  prev = '0;
    time         last_t [5];
    int          n2hz_edges = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {fast, blink, hz2, hz1, fast1};
    endfunction

    function automatic logic [4:0] model_outs();
        logic [4:0] m;
        for (int i = 0; i < 5; i++) m[4-i] = ((k / half_of[i]) % 2) == 1;
        return m;
    endfunction

    // One CLK_REF edge: drive RST, advance the model, compare levels, periods and alignment.
    task automatic step(input logic r);
        logic [4:0] a, m;
        rst = r;
        @(posedge clk);
        #1;
        if (r) k = 0;
        else   k++;
        a = outs();
        m = model_outs();
        for (int i = 0; i < 5; i++)
            check($sformatf("level_%s_k%0d", name_of[i], k), 32'(a[4-i]), 32'(m[4-i]));
        if (r) begin
            for (int i = 0; i < 5; i++) last_t[i] = $time;
            n2hz_edges = 0;
        end else begin
            for (int i = 0; i < 5; i++)
                if (a[4-i] != prev[4-i]) begin
                    check($sformatf("halfperiod_ns_%s", name_of[i]),
                          32'($time - last_t[i]), 32'(half_of[i] * 10));
                    last_t[i] = $time;
                end
            if (a[2] != prev[2]) n2hz_edges++;
            if (a[1] != prev[1]) begin
                check("align_1hz_on_2hz_edge", 32'(a[2] != prev[2]), 32'd1);
                check("align_2hz_edges_per_1hz_toggle", 32'(n2hz_edges), 32'd2);
                n2hz_edges = 0;
            end
        end
        prev = a;
    endtask

    initial begin
        vec_t tbl [15];
        logic [4:0] exp_after [12] = '{
            5'b00001, 5'b10000, 5'b11001, 5'b01000, 5'b01101, 5'b10100,
            5'b10101, 5'b00100, 5'b01101, 5'b11010, 5'b11011, 5'b00010
        };
        int edges;
        bit seen;

        for (int i = 0; i < 3; i++) tbl[i] = '{rst: 1'b1, exp: 5'b00000};
        for (int i = 0; i < 12; i++) tbl[3+i] = '{rst: 1'b0, exp: exp_after[i]};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst);
            check($sformatf("vector_%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Complete 200 free-running edges since release.
        for (int i = 0; i < 188; i++) step(1'b0);

        // Mid-run reset while CLK_1HZ is high with its counter at 7.
        step(1'b1);
        for (int i = 0; i < 17; i++) step(1'b0);
        check("midreset_1hz_high_before", 32'(hz1), 32'd1);
        step(1'b1);
        check("midreset_all_low", 32'(outs()), 32'd0);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 30) begin
            step(1'b0);
            edges++;
            if (hz1) seen = 1;
        end
        check("midreset_1hz_rise_edges", 32'(edges), 32'd10);

        // Reset held high keeps every output low.
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            check("reset_hold_low", 32'(outs()), 32'd0);
        end

        // Random reset pulses over free-running operation.
        for (int i = 0; i < 500; i++) step($urandom_range(0, 19) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
